// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the write-back arbiter slice.
// The optional WB_BYPASS_EN macro is off by default; defining it adds the forwarding ports.
package wb_arbiter_pkg;

   localparam int DEFAULT_XLEN = 32;
   localparam int REG_ADDR_W   = 5;
   localparam logic RST_ACTIVE = 1'b1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

   // x0 is hardwired, so results aimed at it are consumed without a write
   function automatic logic writes_reg(input reg_addr_t rd);
      return rd != ZERO_REG;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and register-file-side signals of the write-back arbiter.
// WB_BYPASS_EN adds the rs1/rs2 forwarding signals.
interface wb_arbiter_if #(
   parameter int XLEN = 32
);
   import wb_arbiter_pkg::*;

   logic            alu_valid;
   reg_addr_t       alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;

   logic            lsu_valid;
   reg_addr_t       lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;

   logic            wb_wen;
   reg_addr_t       wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_busy;

`ifdef WB_BYPASS_EN
   reg_addr_t       rs1;
   reg_addr_t       rs2;
   logic            fwd1_hit;
   logic            fwd2_hit;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;

   modport master (
      output alu_valid, alu_rd, alu_data, input alu_ready,
      output lsu_valid, lsu_rd, lsu_data, input lsu_ready,
      input  wb_wen, wb_rd, wb_data, wb_busy,
      output rs1, rs2,
      input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data, output lsu_ready,
      output wb_wen, wb_rd, wb_data, wb_busy,
      input  rs1, rs2,
      output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );
`else
   modport master (
      output alu_valid, alu_rd, alu_data, input alu_ready,
      output lsu_valid, lsu_rd, lsu_data, input lsu_ready,
      input  wb_wen, wb_rd, wb_data, wb_busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data, output lsu_ready,
      output wb_wen, wb_rd, wb_data, wb_busy
   );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Synchronous circular-buffer FIFO holding {rd, data} ALU results.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   import wb_arbiter_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = count == CW'(DEPTH);
   assign empty    = count == '0;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: serialises LSU and buffered ALU results onto the register-file write port.
// Define WB_BYPASS_EN to add combinational rs1/rs2 forwarding from the output register.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN       = DEFAULT_XLEN,
   parameter int ALU_DEPTH  = 2,
   parameter int STARVE_MAX = 3
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);

   localparam int CW = $clog2(ALU_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int FW = REG_ADDR_W + XLEN;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [FW-1:0]   fifo_head;
   logic [SW-1:0]   starve_cnt;
   logic            lsu_ready_int;
   logic            lsu_win;
   logic            in_reset;
   logic            wen_q;
   reg_addr_t       rd_q;
   logic [XLEN-1:0] data_q;

   assign in_reset = rst == RST_ACTIVE;

   // Readies are forced high in reset, but the in_reset terms below keep anything from being taken
   assign lsu_ready_int = in_reset
                       || !(fifo_count != '0 && starve_cnt == SW'(STARVE_MAX));
   assign bus.lsu_ready = lsu_ready_int;
   assign bus.alu_ready = in_reset || !fifo_full;

   assign lsu_win   = bus.lsu_valid && lsu_ready_int && !in_reset;
   assign fifo_push = bus.alu_valid && !fifo_full && !in_reset;
   assign fifo_pop  = !lsu_win && !fifo_empty && !in_reset;

   wb_fifo #(
      .WIDTH (FW),
      .DEPTH (ALU_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({bus.alu_rd, bus.alu_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Counts LSU wins that overtook a waiting ALU entry; saturating it blocks the LSU for one pop
   always_ff @(posedge clk) begin
      if (in_reset) begin
         starve_cnt <= '0;
      end else if (fifo_pop || fifo_count == '0) begin
         starve_cnt <= '0;
      end else if (lsu_win) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // rd/data hold on idle cycles so only wb_wen marks a fresh write
   always_ff @(posedge clk) begin
      if (in_reset) begin
         wen_q  <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else if (lsu_win) begin
         wen_q  <= writes_reg(bus.lsu_rd);
         rd_q   <= bus.lsu_rd;
         data_q <= bus.lsu_data;
      end else if (fifo_pop) begin
         wen_q  <= writes_reg(fifo_head[FW-1 -: REG_ADDR_W]);
         rd_q   <= fifo_head[FW-1 -: REG_ADDR_W];
         data_q <= fifo_head[XLEN-1:0];
      end else begin
         wen_q  <= 1'b0;
      end
   end

   assign bus.wb_wen  = wen_q;
   assign bus.wb_rd   = rd_q;
   assign bus.wb_data = data_q;
   assign bus.wb_busy = fifo_count != '0 || wen_q;

`ifdef WB_BYPASS_EN
   // Covers the cycle where the register file still returns the pre-write value
   assign bus.fwd1_hit  = wen_q && rd_q == bus.rs1 && bus.rs1 != ZERO_REG;
   assign bus.fwd2_hit  = wen_q && rd_q == bus.rs2 && bus.rs2 != ZERO_REG;
   assign bus.fwd1_data = data_q;
   assign bus.fwd2_data = data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with default parameters (XLEN=32, ALU_DEPTH=2, STARVE_MAX=3).
// Forwarding checks are compiled in only when WB_BYPASS_EN is defined.
module tb_wb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   wb_arbiter_if #(.XLEN(32)) bus ();

   wb_arbiter #(
      .XLEN       (32),
      .ALU_DEPTH  (2),
      .STARVE_MAX (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = adata;
      bus.lsu_valid = lv;
      bus.lsu_rd    = lrd;
      bus.lsu_data  = ldata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle behaviour while the LSU streams against two queued ALU entries
   logic [4:0]  exp_rd   [9] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd24, 5'd25, 5'd26, 5'd11};
   logic        exp_rdy  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [31:0] exp_data [9] = '{32'h114, 32'h115, 32'h116, 32'h117, 32'hA0,
                                 32'h118, 32'h119, 32'h11A, 32'hA1};

   initial begin
      logic [4:0] next_lsu;

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
`endif
      rst = 1'b1;
      tick();
      tick();

      $display("[TB] reset behaviour");
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      #1;
      checkOutput("rst_alu_ready", bus.alu_ready, 1);
      checkOutput("rst_lsu_ready", bus.lsu_ready, 1);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("rst_wen", bus.wb_wen, 0);
      checkOutput("rst_rd", bus.wb_rd, 0);
      checkOutput("rst_data", bus.wb_data, 0);
      checkOutput("rst_busy", bus.wb_busy, 0);
      tick();
      checkOutput("rst_no_accept_wen", bus.wb_wen, 0);
      checkOutput("rst_no_accept_busy", bus.wb_busy, 0);

      $display("[TB] ALU only");
      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("alu_c1_wen", bus.wb_wen, 0);
      checkOutput("alu_c1_busy", bus.wb_busy, 1);
      tick();
      checkOutput("alu_c2_wen", bus.wb_wen, 1);
      checkOutput("alu_c2_rd", bus.wb_rd, 5);
      checkOutput("alu_c2_data", bus.wb_data, 32'h1234);
      tick();
      checkOutput("alu_c3_wen", bus.wb_wen, 0);
      checkOutput("alu_c3_busy", bus.wb_busy, 0);
      checkOutput("alu_c3_rd_hold", bus.wb_rd, 5);
      checkOutput("alu_c3_data_hold", bus.wb_data, 32'h1234);

      $display("[TB] LSU only");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
      #1;
      checkOutput("lsu_ready", bus.lsu_ready, 1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("lsu_c1_wen", bus.wb_wen, 1);
      checkOutput("lsu_c1_rd", bus.wb_rd, 7);
      checkOutput("lsu_c1_data", bus.wb_data, 32'hDEAD_BEEF);
      checkOutput("lsu_ready_after", bus.lsu_ready, 1);
      tick();
      checkOutput("lsu_c2_wen", bus.wb_wen, 0);

      $display("[TB] simultaneous LSU and ALU");
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("both_c1_wen", bus.wb_wen, 1);
      checkOutput("both_c1_rd", bus.wb_rd, 3);
      checkOutput("both_c1_data", bus.wb_data, 32'h33);
      tick();
      checkOutput("both_c2_wen", bus.wb_wen, 1);
      checkOutput("both_c2_rd", bus.wb_rd, 4);
      checkOutput("both_c2_data", bus.wb_data, 32'h44);
      tick();
      checkOutput("both_c3_wen", bus.wb_wen, 0);
      checkOutput("both_c3_busy", bus.wb_busy, 0);

      $display("[TB] starvation bound");
      next_lsu = 5'd20;
      for (int i = 0; i < 9; i++) begin
         if (i == 0)
            applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, next_lsu, 32'h100 + 32'(next_lsu));
         else if (i == 1)
            applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1, next_lsu, 32'h100 + 32'(next_lsu));
         else
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, next_lsu, 32'h100 + 32'(next_lsu));
         #1;
         checkOutput($sformatf("starve_ready_%0d", i), bus.lsu_ready, 32'(exp_rdy[i]));
         tick();
         if (exp_rdy[i]) next_lsu = next_lsu + 5'd1;
         checkOutput($sformatf("starve_wen_%0d", i), bus.wb_wen, 1);
         checkOutput($sformatf("starve_rd_%0d", i), bus.wb_rd, 32'(exp_rd[i]));
         checkOutput($sformatf("starve_data_%0d", i), bus.wb_data, exp_data[i]);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("starve_end_wen", bus.wb_wen, 0);
      checkOutput("starve_end_busy", bus.wb_busy, 0);

      $display("[TB] full FIFO then reset mid-stream");
      applyStimulus(1'b1, 5'd12, 32'hC12, 1'b1, 5'd30, 32'h130);
      tick();
      applyStimulus(1'b1, 5'd13, 32'hC13, 1'b1, 5'd31, 32'h131);
      tick();
      applyStimulus(1'b1, 5'd14, 32'hC14, 1'b1, 5'd1, 32'h101);
      #1;
      checkOutput("full_wb_rd", bus.wb_rd, 31);
      checkOutput("full_alu_ready", bus.alu_ready, 0);
      checkOutput("full_lsu_ready", bus.lsu_ready, 1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_alu_ready", bus.alu_ready, 1);
      checkOutput("midrst_lsu_ready", bus.lsu_ready, 1);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("midrst_wen", bus.wb_wen, 0);
      checkOutput("midrst_rd", bus.wb_rd, 0);
      checkOutput("midrst_data", bus.wb_data, 0);
      checkOutput("midrst_busy", bus.wb_busy, 0);
      tick();
      checkOutput("midrst_c1_wen", bus.wb_wen, 0);
      tick();
      checkOutput("midrst_c2_wen", bus.wb_wen, 0);
      checkOutput("midrst_c2_busy", bus.wb_busy, 0);

      $display("[TB] writes to x0");
      applyStimulus(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("x0_alu_busy", bus.wb_busy, 1);
      tick();
      checkOutput("x0_alu_wen", bus.wb_wen, 0);
      checkOutput("x0_alu_data", bus.wb_data, 32'h77);
      checkOutput("x0_alu_busy_after", bus.wb_busy, 0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h88);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("x0_lsu_wen", bus.wb_wen, 0);
      checkOutput("x0_lsu_data", bus.wb_data, 32'h88);

`ifdef WB_BYPASS_EN
      $display("[TB] forwarding");
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      bus.rs1 = 5'd9;
      bus.rs2 = 5'd8;
      #1;
      checkOutput("fwd1_hit", bus.fwd1_hit, 1);
      checkOutput("fwd1_data", bus.fwd1_data, 32'h55);
      checkOutput("fwd2_miss", bus.fwd2_hit, 0);
      bus.rs1 = 5'd0;
      #1;
      checkOutput("fwd1_zero", bus.fwd1_hit, 0);
      tick();
      bus.rs1 = 5'd9;
      #1;
      checkOutput("fwd1_idle", bus.fwd1_hit, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that drives the single write port of the integer register file. It accepts completed results from two producers, the ALU and the load/store unit (LSU), and serialises them into at most one register write per cycle. ALU results are buffered in a small FIFO, and load results take priority under a bounded-starvation rule. It sits between the execute/memory stages and the register file's `wen`/`rd`/`result` inputs.

## Interface
Parameters:
- `XLEN`, 32, data width; matches the register width.
- `ALU_DEPTH`, 2, ALU result FIFO entries; a power of two, ≥2.
- `STARVE_MAX`, 3, maximum consecutive LSU wins while ALU entries wait.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  FIFO can accept this cycle.
- `lsu_valid`  in  1  load result offered.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  XLEN  load result.
- `lsu_ready`  out  1  load result is taken this cycle.
- `wb_wen`  out  1  register-file write enable (registered).
- `wb_rd`  out  5  register-file write address (registered).
- `wb_data`  out  XLEN  register-file write data (registered).
- `wb_busy`  out  1  FIFO non-empty or `wb_wen` high.
- With `WB_BYPASS_EN` only: `rs1`, `rs2` in 5; `fwd1_hit`, `fwd2_hit` out 1; `fwd1_data`, `fwd2_data` out XLEN.

## Operation
- Handshake: a transfer occurs when valid && ready at a rising edge. Producers hold their payload stable while valid && !ready.
- `alu_ready` = (count < ALU_DEPTH). It depends on the current count only; a pop in the same cycle does not make room.
- `lsu_ready` = !(count != 0 && starve_cnt == STARVE_MAX). It does not depend on `lsu_valid`.
- Selection each cycle, one of:
  - LSU wins if `lsu_valid && lsu_ready`.
  - Otherwise, the FIFO head pops if count != 0.
  - Otherwise, idle.
- Output stage:
  - On a win or pop, the output register loads rd and data.
  - `wb_wen` = 1 if the selected rd != 0. If rd == 0, the result is consumed and dropped, with `wb_wen` = 0.
  - On idle, `wb_wen` = 0 and `wb_rd`/`wb_data` hold their previous values.
- Starvation counter `starve_cnt`, width clog2(STARVE_MAX+1):
  - Increments when the LSU wins and count != 0.
  - Clears on any FIFO pop, and whenever count == 0.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo ALU_DEPTH.
  - Push and pop in the same cycle are legal; count is unchanged.
- Ordering: ALU results retire in acceptance order. No ordering is guaranteed between ALU and LSU. The issue logic must not keep two in-flight writes to the same rd.
- Reset: count, pointers, `starve_cnt`, `wb_wen`, `wb_rd` and `wb_data` all go to 0. Queued entries are discarded, including on a reset mid-stream. During reset, `alu_ready` = 1 and `lsu_ready` = 1, but nothing is accepted.

## Timing
- LSU latency: accepted at edge N, `wb_wen` high during cycle N→N+1, register written at edge N+1.
- ALU latency: pushed at edge N, earliest pop at edge N+1, earliest register write at edge N+2.
- Throughput is one write per cycle, total across both producers.
- A simultaneous `alu_valid` and `lsu_valid` with an empty FIFO:
  - The LSU writes first.
  - The ALU entry is pushed in the same cycle and pops on the next idle-LSU cycle, or after at most STARVE_MAX LSU wins.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwdN_hit` = `wb_wen && wb_rd == rsN && rsN != 0`.
  - `fwdN_data` = `wb_data`; both are combinational.
  - This covers the cycle in which the register file still returns the old value.
- `WB_BYPASS_EN` undefined: the forwarding ports and logic are absent.

## Structure
- The shared defines file supplies the register-width macro, the register-count macro, the zero-register index and the reset-polarity value. No new constants go there except the `WB_BYPASS_EN` default, which is off.
- One sub-module, `wb_fifo`: a parameterised synchronous FIFO with push/pop/full/empty/count ports, holding {rd, data}. The arbiter, counter and output register live in `wb_arbiter`.

## Test plan
- ALU only, rd=5, data=0x1234, pushed at edge 0 → `wb_wen`=1, `wb_rd`=5, `wb_data`=0x1234 in cycle 2→3; `wb_busy` falls after that.
- LSU only, rd=7, data=0xDEAD_BEEF at edge 0 → write visible in cycle 1→2; `lsu_ready` stays 1.
- Both valid with rd=3 and rd=4 → x3 is written first, x4 on the next cycle, exactly one `wb_wen` per cycle.
- LSU streaming continuously with 2 ALU entries queued, STARVE_MAX=3:
  - Three LSU writes occur, then `lsu_ready`=0 for one cycle and the ALU head pops.
  - The pattern repeats until the FIFO empties.
- Fill the FIFO to 2 entries with the LSU blocking → `alu_ready`=0. Assert `rst` mid-stream → all outputs are 0 next cycle and no queued write appears.
- rd=0 from either source → consumed, `wb_wen` stays 0. With `WB_BYPASS_EN`, a write to x9 with data 0x55 while rs1=9 → `fwd1_hit`=1, `fwd1_data`=0x55; rs1=0 → `fwd1_hit`=0.
